// File: rtl/control_sequencer_pkg.sv
// Shared definitions for the control sequencer: state encoding, opcodes,
// branch condition codes and ALU function codes.
package control_sequencer_pkg;

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_T0   = 4'd1,
    S_T1   = 4'd2,
    S_T2   = 4'd3,
    S_T3   = 4'd4,
    S_T4   = 4'd5,
    S_T5   = 4'd6,
    S_T6   = 4'd7,
    S_HALT = 4'd8
  } state_t;

  localparam logic [4:0] OP_BR   = 5'b11011;
  localparam logic [4:0] OP_NOP  = 5'b11000;
  localparam logic [4:0] OP_HALT = 5'b11100;

  localparam logic [1:0] C2_ZERO    = 2'b00;
  localparam logic [1:0] C2_NONZERO = 2'b01;
  localparam logic [1:0] C2_POS     = 2'b10;
  localparam logic [1:0] C2_NEG     = 2'b11;

  localparam logic [4:0] ALU_PASS = 5'b00000;
  localparam logic [4:0] ALU_ADD  = 5'b00011;

endpackage

// File: rtl/branch_cond.sv
// Branch condition evaluator: reduces the bus value to one bit according to
// the C2 field of a branch instruction.
module branch_cond
  import control_sequencer_pkg::*;
(
  input  logic [31:0] bus_in,
  input  logic [1:0]  c2,
  output logic        cond
);

  always_comb begin
    cond = 1'b0;
    case (c2)
      C2_ZERO:    cond = (bus_in == 32'd0);
      C2_NONZERO: cond = (bus_in != 32'd0);
      C2_POS:     cond = ~bus_in[31];
      C2_NEG:     cond = bus_in[31];
      default:    cond = 1'b0;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Fetch/decode/branch control sequencer. Strobes are decoded from the current
// state; T3 additionally looks at the opcode, which is valid in that cycle.
module control_sequencer
  import control_sequencer_pkg::*;
(
  input  logic        clk,
  input  logic        clr,
  input  logic        run,
  input  logic [31:0] ir,
  input  logic [31:0] bus_in,
  output logic        PCout,
  output logic        MARins,
  output logic        incPC,
  output logic        ZLOins,
  output logic        ZLOout,
  output logic        PCins,
  output logic        MDRRead,
  output logic        MDRins,
  output logic        MDRout,
  output logic        IRins,
  output logic        Gra,
  output logic        Rout,
  output logic        Yins,
  output logic        Cout,
  output logic        CONins,
  output logic [4:0]  alu_op,
  output logic        con_ff,
  output logic        done,
  output logic        halted,
  output logic        illegal,
  output state_t      state_dbg
);

  state_t     state, state_nxt;
  logic [4:0] opcode;
  logic       cond;
  logic       is_br, is_nop, is_halt;

  assign opcode  = ir[31:27];
  assign is_br   = (opcode == OP_BR);
  assign is_nop  = (opcode == OP_NOP);
  assign is_halt = (opcode == OP_HALT);
  assign state_dbg = state;

  branch_cond u_branch_cond (
    .bus_in (bus_in),
    .c2     (ir[20:19]),
    .cond   (cond)
  );

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state  <= S_IDLE;
      con_ff <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == S_T3 && is_br)
        con_ff <= cond;
    end
  end

  // Only one of PCout/ZLOout/MDRout/Rout/Cout is ever set in a given state.
  always_comb begin
    state_nxt = state;
    PCout     = 1'b0;
    MARins    = 1'b0;
    incPC     = 1'b0;
    ZLOins    = 1'b0;
    ZLOout    = 1'b0;
    PCins     = 1'b0;
    MDRRead   = 1'b0;
    MDRins    = 1'b0;
    MDRout    = 1'b0;
    IRins     = 1'b0;
    Gra       = 1'b0;
    Rout      = 1'b0;
    Yins      = 1'b0;
    Cout      = 1'b0;
    CONins    = 1'b0;
    alu_op    = ALU_PASS;
    done      = 1'b0;
    halted    = 1'b0;
    illegal   = 1'b0;
    case (state)
      S_IDLE: if (run) state_nxt = S_T0;
      S_T0: begin
        PCout     = 1'b1;
        MARins    = 1'b1;
        incPC     = 1'b1;
        ZLOins    = 1'b1;
        state_nxt = S_T1;
      end
      S_T1: begin
        ZLOout    = 1'b1;
        PCins     = 1'b1;
        MDRRead   = 1'b1;
        MDRins    = 1'b1;
        state_nxt = S_T2;
      end
      S_T2: begin
        MDRout    = 1'b1;
        IRins     = 1'b1;
        state_nxt = S_T3;
      end
      S_T3: begin
        if (is_br) begin
          Gra       = 1'b1;
          Rout      = 1'b1;
          CONins    = 1'b1;
          state_nxt = S_T4;
        end else if (is_halt) begin
          state_nxt = S_HALT;
        end else begin
          done      = 1'b1;
          illegal   = ~is_nop;
          state_nxt = run ? S_T0 : S_IDLE;
        end
      end
      S_T4: begin
        PCout     = 1'b1;
        Yins      = 1'b1;
        state_nxt = S_T5;
      end
      S_T5: begin
        Cout      = 1'b1;
        ZLOins    = 1'b1;
        alu_op    = ALU_ADD;
        state_nxt = S_T6;
      end
      S_T6: begin
        ZLOout    = 1'b1;
        PCins     = con_ff;
        done      = 1'b1;
        state_nxt = run ? S_T0 : S_IDLE;
      end
      S_HALT: halted = 1'b1;
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: walks branch, NOP, illegal and HALT
// instructions cycle by cycle and checks strobes, flags and reset behaviour.
module tb_control_sequencer;
  import control_sequencer_pkg::*;

  logic        clk, clr, run;
  logic [31:0] ir, bus_in;
  logic        PCout, MARins, incPC, ZLOins, ZLOout, PCins, MDRRead, MDRins;
  logic        MDRout, IRins, Gra, Rout, Yins, Cout, CONins;
  logic [4:0]  alu_op;
  logic        con_ff, done, halted, illegal;
  state_t      state_dbg;
  logic [14:0] strobes;

  int checks = 0;
  int errors = 0;

  // Bit order: PCout MARins incPC ZLOins ZLOout PCins MDRRead MDRins
  //            MDRout IRins Gra Rout Yins Cout CONins
  localparam logic [14:0] ST_NONE = 15'h0000;
  localparam logic [14:0] ST_T0   = 15'h7800;
  localparam logic [14:0] ST_T1   = 15'h0780;
  localparam logic [14:0] ST_T2   = 15'h0060;
  localparam logic [14:0] ST_T3BR = 15'h0019;
  localparam logic [14:0] ST_T4   = 15'h4004;
  localparam logic [14:0] ST_T5   = 15'h0802;
  localparam logic [14:0] ST_T6PC = 15'h0600;
  localparam logic [14:0] ST_T6   = 15'h0400;

  assign strobes = {PCout, MARins, incPC, ZLOins, ZLOout, PCins, MDRRead, MDRins,
                    MDRout, IRins, Gra, Rout, Yins, Cout, CONins};

  control_sequencer dut (
    .clk(clk), .clr(clr), .run(run), .ir(ir), .bus_in(bus_in),
    .PCout(PCout), .MARins(MARins), .incPC(incPC), .ZLOins(ZLOins),
    .ZLOout(ZLOout), .PCins(PCins), .MDRRead(MDRRead), .MDRins(MDRins),
    .MDRout(MDRout), .IRins(IRins), .Gra(Gra), .Rout(Rout), .Yins(Yins),
    .Cout(Cout), .CONins(CONins), .alu_op(alu_op), .con_ff(con_ff),
    .done(done), .halted(halted), .illegal(illegal), .state_dbg(state_dbg)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_st(input string tag, input state_t exp_s, input logic [14:0] exp_strb);
    chk({tag, ".state"}, 32'(state_dbg), 32'(exp_s));
    chk({tag, ".strobes"}, 32'(strobes), 32'(exp_strb));
  endtask

  // Bus drivers must never overlap, checked every cycle
  always @(negedge clk)
    chk("bus_excl", 32'($countones({PCout, ZLOout, MDRout, Rout, Cout}) <= 1), 32'd1);

  // Full branch instruction from T0 to T6; run is dropped in T1 when keep_run=0
  task automatic run_br(input logic [31:0] ir_v, input logic [31:0] bus_v,
                        input logic exp_con, input logic keep_run);
    ir = ir_v;
    bus_in = bus_v;
    step(); chk_st("br.t0", S_T0, ST_T0);
    step(); chk_st("br.t1", S_T1, ST_T1);
    run = keep_run;
    step(); chk_st("br.t2", S_T2, ST_T2);
    step(); chk_st("br.t3", S_T3, ST_T3BR);
    chk("br.t3.done", 32'(done), 32'd0);
    step(); chk_st("br.t4", S_T4, ST_T4);
    chk("br.t4.con_ff", 32'(con_ff), 32'(exp_con));
    chk("br.t4.alu", 32'(alu_op), 32'(ALU_PASS));
    step(); chk_st("br.t5", S_T5, ST_T5);
    chk("br.t5.alu", 32'(alu_op), 32'(ALU_ADD));
    step(); chk_st("br.t6", S_T6, exp_con ? ST_T6PC : ST_T6);
    chk("br.t6.done", 32'(done), 32'd1);
  endtask

  // Driver: directed steps
  initial begin
    clr = 1'b1; run = 1'b0; ir = '0; bus_in = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_st("rst", S_IDLE, ST_NONE);
    chk("rst.flags", {27'd0, alu_op}, 32'd0);
    chk("rst.status", 32'({con_ff, done, halted, illegal}), 32'd0);
    clr = 1'b0;
    step(); chk_st("idle.hold", S_IDLE, ST_NONE);

    // BR C2=00, bus 0 -> taken; run held so T6 returns to T0
    run = 1'b1;
    run_br(32'hD8000000, 32'h0, 1'b1, 1'b1);
    // BR C2=01, bus 0 -> not taken; run dropped mid-instruction
    run_br(32'hD8080000, 32'h0, 1'b0, 1'b0);
    step(); chk_st("br2.idle", S_IDLE, ST_NONE);
    // C2=11 / C2=10 on a negative bus value
    run = 1'b1;
    run_br(32'hD8180000, 32'h80000012, 1'b1, 1'b1);
    run_br(32'hD8100000, 32'h80000012, 1'b0, 1'b0);
    step(); chk_st("br4.idle", S_IDLE, ST_NONE);

    // NOP then illegal opcode, back-to-back
    run = 1'b1; ir = 32'hC0000000;
    step(); chk_st("nop.t0", S_T0, ST_T0);
    step(); step();
    step(); chk_st("nop.t3", S_T3, ST_NONE);
    chk("nop.done", 32'(done), 32'd1);
    chk("nop.illegal", 32'(illegal), 32'd0);
    ir = 32'h08000000;
    step(); chk_st("ill.t0", S_T0, ST_T0);
    step(); step();
    step(); chk_st("ill.t3", S_T3, ST_NONE);
    chk("ill.flags", 32'({illegal, done}), 32'b11);
    run = 1'b0;
    step(); chk_st("ill.idle", S_IDLE, ST_NONE);
    chk("ill.idle.flags", 32'({illegal, done}), 32'b00);

    // HALT holds for 20 cycles until clr
    run = 1'b1; ir = 32'hE0000000;
    repeat (4) step();
    chk_st("halt.t3", S_T3, ST_NONE);
    chk("halt.t3.done", 32'(done), 32'd0);
    for (int i = 0; i < 20; i++) begin
      step();
      chk_st("halt.hold", S_HALT, ST_NONE);
      chk("halt.flag", 32'({halted, done}), 32'b10);
    end
    #2 clr = 1'b1;
    #1;
    chk_st("halt.clr", S_IDLE, ST_NONE);
    chk("halt.clr.halted", 32'(halted), 32'd0);
    step();
    clr = 1'b0;
    step(); chk_st("halt.resume", S_T0, ST_T0);

    // clr in T5 of a taken branch
    ir = 32'hD8000000; bus_in = 32'h0;
    repeat (5) step();
    chk_st("clr5.t5", S_T5, ST_T5);
    chk("clr5.con_ff", 32'(con_ff), 32'd1);
    #2 clr = 1'b1;
    #1;
    chk_st("clr5.async", S_IDLE, ST_NONE);
    chk("clr5.outs", 32'({alu_op, con_ff, done, halted, illegal}), 32'd0);
    step();
    clr = 1'b0; run = 1'b0;
    step(); chk_st("clr5.idle", S_IDLE, ST_NONE);
    run = 1'b1;
    step(); chk_st("clr5.restart", S_T0, ST_T0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock; all state changes on its rising edge.
REQ-002 SHALL have port clr, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port run, input, 1 bit: high permits a new instruction fetch.
REQ-004 SHALL have port ir, input, 32 bits: instruction register contents; opcode ir[31:27], C2 field ir[20:19].
REQ-005 SHALL have port bus_in, input, 32 bits: datapath bus value, sampled for the branch condition.
REQ-006 SHALL have ports PCout, MARins, incPC, ZLOins, ZLOout, PCins, MDRRead, MDRins, MDRout, IRins, Gra, Rout, Yins, Cout, CONins, each output 1 bit: datapath strobes, active high.
REQ-007 SHALL have port alu_op, output, 5 bits: ALU function; 5'b00011 means ADD, 5'b00000 means pass.
REQ-008 SHALL have port con_ff, output, 1 bit: latched branch-condition result.
REQ-009 SHALL have ports done, halted and illegal, each output 1 bit: instruction complete pulse, halt status, and unknown-opcode pulse.

Function
REQ-010 SHALL implement states IDLE, T0, T1, T2, T3, T4, T5, T6, HALT; exactly one state per clk cycle; outputs decoded from current state (Moore).
REQ-011 IDLE: all strobes low; go to T0 when run=1, else hold.
REQ-012 T0: PCout, MARins, incPC, ZLOins high; go to T1.
REQ-013 T1: ZLOout, PCins, MDRRead, MDRins high; go to T2.
REQ-014 T2: MDRout, IRins high; go to T3.
REQ-015 T3 decodes ir[31:27], which is valid this cycle: BR=5'b11011, NOP=5'b11000, HALT=5'b11100.
REQ-016 T3 with BR: Gra, Rout, CONins high; con_ff loads the condition from bus_in at the end of the cycle; go to T4.
REQ-017 Condition by C2: 00 → bus_in==0; 01 → bus_in!=0; 10 → bus_in[31]==0; 11 → bus_in[31]==1.
REQ-018 T3 with NOP: done pulses for 1 cycle; go to T0 if run=1, else IDLE.
REQ-019 T3 with HALT: go to HALT; halted=1 and stays until clr; all strobes low in HALT.
REQ-020 T3 with any other opcode: illegal and done pulse together for 1 cycle; next state as for NOP.
REQ-021 T4: PCout, Yins high; go to T5.
REQ-022 T5: Cout high, alu_op=ADD, ZLOins high; go to T6.
REQ-023 T6: ZLOout high; PCins high only if con_ff=1; done pulses; go to T0 if run=1, else IDLE.
REQ-024 alu_op SHALL be pass (5'b00000) in every state except T5.
REQ-025 Fetch latency: T0 to T3 = 3 cycles; BR total 7 cycles; NOP 4 cycles.
REQ-026 run is sampled only in IDLE, T3 (non-BR) and T6; dropping run mid-instruction does not abort it.
REQ-027 No two mutually exclusive bus drivers (PCout, ZLOout, MDRout, Rout, Cout) SHALL ever be high in the same cycle.

Reset
REQ-028 clr=1 SHALL immediately force IDLE, all strobes 0, alu_op=0, con_ff=0, done=0, illegal=0, halted=0.
REQ-029 clr asserted mid-instruction SHALL abandon it with no further strobes; after release, operation resumes at IDLE.

Structure
REQ-030 A shared package SHALL hold the state encoding, opcode constants (BR, NOP, HALT), C2 codes and alu_op codes.
REQ-031 The condition evaluator (bus_in, C2 → 1 bit) SHALL be one sub-module, branch_cond.

Verification
REQ-032 Reset, then run=1 with ir=32'hD8000000 (BR, C2=00) and bus_in=0 in T3 → con_ff=1, PCins high in T6, done at T6, 7 cycles total.
REQ-033 BR with C2=01 (ir=32'hD8080000) and bus_in=0 → con_ff=0, PCins low in T6.
REQ-034 BR with C2=11 and bus_in=32'h80000012 → con_ff=1; the same instruction with C2=10 → con_ff=0.
REQ-035 ir=32'hC0000000 (NOP) → done at T3, back to T0 with run=1; ir=32'h08000000 → illegal and done pulse together.
REQ-036 ir=32'hE0000000 (HALT) → halted=1 held for 20 cycles with no strobes; clr pulse → IDLE, halted=0.
REQ-037 clr asserted in T5 → all outputs 0 before the next clk edge; every cycle checked against REQ-027.
